// File: rtl/serial_alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_alu_seq_if
//  Purpose  : Host-side request/response bundle for the bit-serial sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface serial_alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;

    modport master (
        output start, op, a, b, cin,
        input  busy, done, result, cout, zero
    );

    modport slave (
        input  start, op, a, b, cin,
        output busy, done, result, cout, zero
    );
endinterface
`default_nettype wire

// File: rtl/serial_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : serial_alu_seq
//  Purpose  : Drives an external 1-bit ALU slice LSB-first to build a
//             WIDTH-bit result with carry and zero flags.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_alu_seq_if.slave host,
    output logic            alu_a,
    output logic            alu_b,
    output logic            alu_cin,
    output logic [1:0]      alu_op,
    input  logic            alu_result,
    input  logic            alu_cout
);
    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   c_LAST   = CW'(WIDTH - 1);
    localparam logic [1:0]      c_OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [1:0]       r_op;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_res_next;
    logic             w_carry_next;
    logic             w_run;

    // The slice's raw carry-out is only meaningful for ADD; logic ops forward 0.
    assign w_res_next   = {alu_result, r_res_sh[WIDTH-1:1]};
    assign w_carry_next = (r_op == c_OP_ADD) & alu_cout;
    assign w_run        = (r_state == S_RUN);

    assign alu_a   = w_run & r_a_sh[0];
    assign alu_b   = w_run & r_b_sh[0];
    assign alu_cin = w_run & r_carry;
    assign alu_op  = r_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_res_sh    <= '0;
            r_op        <= 2'b00;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            host.busy   <= 1'b0;
            host.done   <= 1'b0;
            host.result <= '0;
            host.cout   <= 1'b0;
            host.zero   <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_res_sh <= w_res_next;
                    r_carry  <= w_carry_next;
                    if (r_cnt == c_LAST) begin
                        r_state     <= S_DONE;
                        host.busy   <= 1'b0;
                        host.done   <= 1'b1;
                        host.result <= w_res_next;
                        host.cout   <= w_carry_next;
                        host.zero   <= (w_res_next == '0);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request
                    host.done <= 1'b0;
                    if (host.start) begin
                        r_state   <= S_RUN;
                        r_a_sh    <= host.a;
                        r_b_sh    <= host.b;
                        r_op      <= host.op;
                        r_carry   <= host.cin;
                        r_res_sh  <= '0;
                        r_cnt     <= '0;
                        host.busy <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/serial_alu_seq.md
# serial_alu_seq

Bit-serial sequencer that drives an external 1-bit ALU slice (op encoding 00 AND, 01 OR, 10 XOR, 11 ADD with carry) to perform one WIDTH-bit operation, one bit per clock, LSB first. It sits directly upstream of the slice:
- it latches the operands and presents one bit pair per cycle to the slice;
- it feeds the slice's carry-out back as the next carry-in;
- it assembles the slice's results into a WIDTH-bit word with carry and zero flags.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a new operation; sampled only in IDLE or DONE
- op  input  2  operation code, latched on start acceptance
- a  input  WIDTH  operand A, latched on start acceptance
- b  input  WIDTH  operand B, latched on start acceptance
- cin  input  1  initial carry-in, latched on start acceptance (used for ADD only)
- busy  output  1  high while bits are being processed (state RUN)
- done  output  1  one-cycle pulse: result/cout/zero valid from this cycle
- result  output  WIDTH  assembled result; held until next accepted start
- cout  output  1  final carry-out (ADD); 0 for logic ops
- zero  output  1  high when result == 0
- alu_a, alu_b, alu_cin  output  1 each  current bit pair and carry driven to slice
- alu_op  output  2  latched op driven to slice
- alu_result, alu_cout  input  1 each  combinational slice outputs, same cycle

## Operation
- States:
  - IDLE: start=1 → latch a, b, op, cin; clear bit counter; go to RUN.
  - RUN: each cycle, process one bit.
    - Drive alu_a=a_sh[0], alu_b=b_sh[0], alu_cin=carry_q, alu_op=op_q.
    - At the edge, shift a_sh/b_sh right and shift alu_result into the MSB of res_sh (shift right).
    - carry_q <= alu_cout if op_q==11, else 0.
    - Counter increments; when counter==WIDTH-1 at the edge, go to DONE.
  - DONE: one cycle.
    - done=1.
    - start=1 is accepted exactly as in IDLE (go to RUN with new operands).
    - Otherwise go to IDLE.
- result/cout/zero are registered when the final bit is captured (transition to DONE).
  - cout = final carry_q value: alu_cout of the last bit for ADD, 0 otherwise.
  - zero = (final result == 0).
- start in RUN is ignored: no relatch, no restart.
- Slice drive outside RUN: alu_a=alu_b=alu_cin=0, alu_op=op_q.
- Carry is initialised from the latched cin for ADD. For logic ops the slice ignores the carry; alu_cin is still driven with the latched cin in bit 0.
- ADD overflow beyond WIDTH bits appears only on cout; result wraps modulo 2^WIDTH.
- Counter width is clog2(WIDTH); it never counts past WIDTH-1.

## Timing
- Reset (asynchronous assertion, release synchronous to clk): state=IDLE, busy=0, done=0, result=0, cout=0, zero=0, all internal shift/carry/counter registers 0, alu_* outputs 0.
- Reset asserted mid-RUN aborts immediately. No done pulse follows; result reads 0.
- Latency: start sampled at edge E0 → busy=1 from E0 to E_WIDTH → done=1 during the cycle after edge E_WIDTH. That is WIDTH+1 cycles from start to done.
- Throughput: back-to-back start held high gives one result every WIDTH+1 cycles.
  - DONE overlaps the next acceptance, so busy deasserts for exactly one cycle.
- result, cout and zero change only at the E_WIDTH capture edge and at reset.

## Test plan
- WIDTH=8, ADD: a=8'hFF, b=8'h01, cin=0 → after 9 cycles done=1, result=8'h00, cout=1, zero=1.
- WIDTH=8, ADD with carry: a=8'h7F, b=8'h00, cin=1 → result=8'h80, cout=0, zero=0. Also a=8'h3C, b=8'hC3, cin=1 → result=8'h00, cout=1.
- WIDTH=8, logic ops on a=8'hA5, b=8'h5A:
  - XOR → 8'hFF, cout=0.
  - AND → 8'h00, zero=1.
  - OR → 8'hFF.
  - Repeat with cin=1: cout stays 0.
- start re-pulsed with different operands at cycle 3 of RUN → ignored; original result delivered at cycle 9; busy stays high throughout.
- start held high continuously with new operands presented at each DONE:
  - done pulses every 9 cycles;
  - busy low exactly one cycle between operations;
  - each result matches its own operands.
- rst_n pulled low at cycle 4 of an ADD → busy/done/result/cout/zero=0 immediately (asynchronous); after release, a fresh start completes correctly in 9 cycles.
